// File: rtl/memory_bus_arbiter.sv
// rtl/memory_bus_arbiter.sv - round-robin arbiter sharing one MemoryBus request/response channel
module memory_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic [1:0]                bus_req_type,
  output logic [ID_W-1:0]           bus_req_source,
  output logic [ADDR_W-1:0]         bus_req_addr,
  output logic [DATA_W-1:0]         bus_req_data,
  input  logic                      bus_rsp_valid,
  input  logic [ID_W-1:0]           bus_rsp_source,
  input  logic [DATA_W-1:0]         bus_rsp_data,
  output logic                      bus_rsp_ready,
  output logic                      stray_rsp
);

  localparam int ID_SPACE = 2 ** ID_W;
  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                stray_q, stray_d;

  // Requester-indexed views padded to the full BusID space so a BusID indexes them exactly.
  logic [ID_SPACE-1:0] valid_pad;
  logic [ID_SPACE-1:0] write_pad;
  logic [ADDR_W-1:0]   addr_arr  [ID_SPACE];
  logic [DATA_W-1:0]   wdata_arr [ID_SPACE];

  for (genvar g = 0; g < ID_SPACE; g++) begin : g_unpack
    if (g < NUM_REQ) begin : g_used
      assign valid_pad[g] = req_valid[g];
      assign write_pad[g] = req_write[g];
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign valid_pad[g] = 1'b0;
      assign write_pad[g] = 1'b0;
      assign addr_arr[g]  = '0;
      assign wdata_arr[g] = '0;
    end
  end

  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand_id;
  int              cand_int;

  // Scan from the requester after the last grant, wrapping once around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_id   = '0;
    cand_int  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_int = int'(last_grant_q) + k;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand_id = ID_W'(cand_int);
      if (!win_found && valid_pad[cand_id]) begin
        win_found = 1'b1;
        win_idx   = cand_id;
      end
    end
  end

  logic rsp_match;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    stray_d      = stray_q;
    rsp_match    = bus_rsp_valid && (state_q == S_WAIT) && (bus_rsp_source == id_q);

    if (bus_rsp_valid && !rsp_match) stray_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d      = S_ISSUE;
          last_grant_d = win_idx;
          id_d         = win_idx;
          write_d      = write_pad[win_idx];
          addr_d       = addr_arr[win_idx];
          data_d       = write_pad[win_idx] ? wdata_arr[win_idx] : '0;
        end
      end
      S_ISSUE: begin
        if (bus_req_ready) begin
          if (write_q) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A matching response beats a timeout expiring in the same cycle.
        if (rsp_match) begin
          rsp_data_d = bus_rsp_data;
          rsp_err_d  = 1'b0;
          state_d    = S_DELIVER;
        end else if (cnt_q >= TIMEOUT_C) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_DELIVER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DELIVER: begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      stray_q      <= stray_d;
    end
  end

  logic [ID_SPACE-1:0] ready_pad;
  logic [ID_SPACE-1:0] rsp_pad;

  always_comb begin
    ready_pad = '0;
    rsp_pad   = '0;
    if (rst_n && (state_q == S_IDLE) && win_found) ready_pad[win_idx] = 1'b1;
    if (state_q == S_DELIVER) rsp_pad[id_q] = 1'b1;
  end

  assign req_ready      = ready_pad[NUM_REQ-1:0];
  assign rsp_valid      = rsp_pad[NUM_REQ-1:0];
  assign rsp_data       = (state_q == S_DELIVER) ? rsp_data_q : '0;
  assign rsp_err        = (state_q == S_DELIVER) && rsp_err_q;
  assign bus_req_valid  = (state_q == S_ISSUE);
  assign bus_req_type   = {1'b0, write_q};
  assign bus_req_source = id_q;
  assign bus_req_addr   = addr_q;
  assign bus_req_data   = data_q;
  // Responses are always drained; only the held-in-reset case reports not ready.
  assign bus_rsp_ready  = rst_n;
  assign stray_rsp      = stray_q;

endmodule
